piso_shift_reg: RTL and testbench

- Parallel-in, serial-out shift register.
- Captures an N-bit word on a load strobe, then presents it one bit per clock on a single serial output.
- Sits at the edge of a serial transmit path (e.g. in front of a line driver or serializer framing stage).
- Provides busy/valid/done status so an upstream block can pace word loads.

---
 rtl/piso_pkg.sv | 9 +
 rtl/piso_bit_counter.sv | 31 +++
 rtl/piso_shift_reg.sv | 52 +++++
 tb/tb_piso_shift_reg.sv | 138 +++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in / serial-out shifter.
package piso_pkg;
  localparam int PISO_W_DEFAULT = 4;

  // Counter must hold the full word length n, hence n+1 states.
  function automatic int piso_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// Loadable remaining-bit down-counter; zero/one flags drive valid and done.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int N  = PISO_W_DEFAULT,
  parameter int CW = piso_cnt_w(N)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic load_i,
  output logic nz_o,
  output logic one_o
);
  localparam logic [CW-1:0] LOAD_V = CW'(N);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = LOAD_V;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign nz_o  = (cnt_q != '0);
  assign one_o = (cnt_q == CW'(1));
endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with busy/valid/done pacing status.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int n         = PISO_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [n-1:0] i_parallel_in,
  output logic         o_serial_out,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done
);
  logic [n-1:0] sr_q, sr_d, sr_sh;
  logic         nz, one;

  piso_bit_counter #(.N(n)) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load_i (i_load),
    .nz_o   (nz),
    .one_o  (one)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_sh = {sr_q[n-2:0], 1'b0};
    end else begin : g_lsb
      assign sr_sh = {1'b0, sr_q[n-1:1]};
    end
  endgenerate

  // Load wins over shift so a mid-word load restarts cleanly.
  always_comb begin
    sr_d = sr_q;
    if (i_load)  sr_d = i_parallel_in;
    else if (nz) sr_d = sr_sh;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign o_serial_out = nz & (MSB_FIRST ? sr_q[n-1] : sr_q[0]);
  assign o_valid      = nz;
  assign o_busy       = nz;
  assign o_done       = one;
endmodule

// File: tb/tb_piso_shift_reg.sv
// Scoreboard bench: dut 0 is MSB-first, dut 1 is LSB-first, both n=4.
module tb_piso_shift_reg;
  typedef struct packed { logic b; logic d; } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [1:0] load  = '0;
  logic [1:0][3:0] pin = '0;
  logic [1:0] ser, vld, bsy, dn;

  exp_t exp_q[2][$];
  int   run_q[2][$];
  int   run[2];
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  piso_shift_reg #(.n(4), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(load[0]), .i_parallel_in(pin[0]),
    .o_serial_out(ser[0]), .o_valid(vld[0]), .o_busy(bsy[0]), .o_done(dn[0]));

  piso_shift_reg #(.n(4), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(load[1]), .i_parallel_in(pin[1]),
    .o_serial_out(ser[1]), .o_valid(vld[1]), .o_busy(bsy[1]), .o_done(dn[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_bits(input int d, input logic [7:0] bits, input int cnt, input logic last_done);
    for (int i = cnt - 1; i >= 0; i--) begin
      exp_t e;
      e.b = bits[i];
      e.d = (i == 0) ? last_done : 1'b0;
      exp_q[d].push_back(e);
    end
  endtask

  // Monitor: pops one expected bit per valid cycle, checks idle outputs, run lengths.
  always @(negedge i_clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_eq_valid%0d", d), bsy[d], vld[d]);
      if (vld[d]) begin
        if (exp_q[d].size() == 0) begin
          chk($sformatf("unexpected_bit%0d", d), 1, 0);
        end else begin
          exp_t e;
          e = exp_q[d].pop_front();
          chk($sformatf("serial%0d", d), ser[d], e.b);
          chk($sformatf("done%0d", d), dn[d], e.d);
        end
        run[d]++;
      end else begin
        chk($sformatf("idle_serial%0d", d), ser[d], 0);
        chk($sformatf("idle_done%0d", d), dn[d], 0);
        if (run[d] != 0) begin
          if (run_q[d].size() == 0) chk($sformatf("unexpected_run%0d", d), run[d], 0);
          else chk($sformatf("run_len%0d", d), run[d], run_q[d].pop_front());
          run[d] = 0;
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge i_clk);
    #1;
  endtask

  initial begin
    run[0] = 0; run[1] = 0;
    // Reset held with load asserted: outputs must stay quiet.
    load = 2'b11; pin[0] = 4'b1010; pin[1] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); #1;
      chk("rst_serial", ser, 2'b00);
      chk("rst_valid", vld, 2'b00);
      chk("rst_done", dn, 2'b00);
    end
    load = 2'b00;
    tick(1);
    i_rst = 1'b1;
    tick(2);

    // Basic MSB-first 1010.
    push_bits(0, 8'b1010, 4, 1'b1); run_q[0].push_back(4);
    load[0] = 1'b1; pin[0] = 4'b1010;
    tick(1); load[0] = 1'b0;
    tick(6);

    // LSB-first 1101 -> 1,0,1,1.
    push_bits(1, 8'b1011, 4, 1'b1); run_q[1].push_back(4);
    load[1] = 1'b1; pin[1] = 4'b1101;
    tick(1); load[1] = 1'b0;
    tick(6);

    // Reload mid-word: 1111 for two bits, then 0001.
    push_bits(0, 8'b11, 2, 1'b0);
    push_bits(0, 8'b0001, 4, 1'b1); run_q[0].push_back(6);
    load[0] = 1'b1; pin[0] = 4'b1111;
    tick(1); load[0] = 1'b0;
    tick(1); load[0] = 1'b1; pin[0] = 4'b0001;
    tick(1); load[0] = 1'b0;
    tick(6);

    // Async reset after two bits of 1010.
    push_bits(0, 8'b10, 2, 1'b0); run_q[0].push_back(2);
    load[0] = 1'b1; pin[0] = 4'b1010;
    tick(1); load[0] = 1'b0;
    @(posedge i_clk); @(negedge i_clk); #2;
    i_rst = 1'b0;
    #1;
    chk("arst_serial", ser[0], 0);
    chk("arst_valid", vld[0], 0);
    chk("arst_done", dn[0], 0);
    tick(1); i_rst = 1'b1;
    tick(6);

    // Held load 1000 for five edges, then the tail 0,0,0 with done.
    push_bits(0, 8'b11111, 5, 1'b0);
    push_bits(0, 8'b000, 3, 1'b1); run_q[0].push_back(8);
    load[0] = 1'b1; pin[0] = 4'b1000;
    tick(5); load[0] = 1'b0;
    tick(6);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("leftover_bits%0d", d), exp_q[d].size(), 0);
      chk($sformatf("leftover_runs%0d", d), run_q[d].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
